adiv5_mem_seq: RTL and testbench

//  Upstream feeder of the ADIv5 command FIFO in ahb3lite_remote_bridge2.

---
 rtl/adiv5_mem_seq_pkg.sv | 34 +++
 rtl/adiv5_mem_seq_if.sv | 36 +++
 rtl/adiv5_mem_seq.sv | 191 +++++++++++++++++++
 tb/tb_adiv5_mem_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adiv5_mem_seq_pkg.sv
// Shared types and constants for the ADIv5 MEM-AP access sequencer.
// Command/response layouts match the bridge's ADIv5 command/response FIFOs.
package adiv5_mem_seq_pkg;

    localparam int ADIv5_CMD_WIDTH  = 36;
    localparam int ADIv5_RESP_WIDTH = 35;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  a;
        logic        apndp;
        logic        rnw;
    } adiv5_cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  ack;
    } adiv5_resp_t;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [1:0] DP_SELECT = 2'b10;
    localparam logic [1:0] DP_RDBUFF = 2'b11;
    localparam logic [1:0] AP_CSW    = 2'b00;
    localparam logic [1:0] AP_TAR    = 2'b01;
    localparam logic [1:0] AP_DRW    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_CSW, S_TAR, S_DRW, S_RDBUF, S_DRAIN, S_DONE
    } state_e;

endpackage

// File: rtl/adiv5_mem_seq_if.sv
// Request/completion port plus ADIv5 command/response FIFO port of the sequencer.
interface adiv5_mem_seq_if;
    import adiv5_mem_seq_pkg::*;

    logic                        REQ_VALID;
    logic                        REQ_READY;
    logic                        REQ_WRITE;
    logic [1:0]                  REQ_SIZE;
    logic [31:0]                 REQ_ADDR;
    logic [31:0]                 REQ_WDATA;
    logic                        RESP_VALID;
    logic [31:0]                 RESP_RDATA;
    logic                        RESP_ERR;
    logic                        INVALIDATE;
    logic [ADIv5_CMD_WIDTH-1:0]  ADIv5_WRDATA;
    logic                        ADIv5_WREN;
    logic                        ADIv5_WRFULL;
    logic [ADIv5_RESP_WIDTH-1:0] ADIv5_RDDATA;
    logic                        ADIv5_RDEN;
    logic                        ADIv5_RDEMPTY;

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_ADDR, REQ_WDATA, INVALIDATE,
               ADIv5_WRFULL, ADIv5_RDDATA, ADIv5_RDEMPTY,
        output REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR,
               ADIv5_WRDATA, ADIv5_WREN, ADIv5_RDEN
    );

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_SIZE, REQ_ADDR, REQ_WDATA, INVALIDATE,
               ADIv5_WRFULL, ADIv5_RDDATA, ADIv5_RDEMPTY,
        input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR,
               ADIv5_WRDATA, ADIv5_WREN, ADIv5_RDEN
    );

endinterface

// File: rtl/adiv5_mem_seq.sv
// Turns one 32-bit memory request into cached SELECT/CSW/TAR writes plus DRW/RDBUFF.
// Optional ADIv5_AUTOINC_EN: single-increment TAR tracking so sequential accesses skip TAR.
module adiv5_mem_seq
    import adiv5_mem_seq_pkg::*;
#(
    parameter logic [7:0]  AP_SEL    = 8'h00,
    parameter logic [31:0] CSW_BASE  = 32'h2300_0000,
    parameter int          MAX_OUTST = 3
) (
    input logic            CLK,
    input logic            RESETn,
    adiv5_mem_seq_if.slave bus
);

    localparam int OW = $clog2(MAX_OUTST + 1);
`ifdef ADIv5_AUTOINC_EN
    localparam logic [31:0] CSW_INC = 32'h0000_0010;
`else
    localparam logic [31:0] CSW_INC = 32'h0000_0000;
`endif

    state_e          state_q, state_d;
    logic            rdy_q, rdy_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            sel_vld_q, sel_vld_d;
    logic            csw_vld_q, csw_vld_d;
    logic [1:0]      csw_size_q, csw_size_d;
    logic            tar_vld_q, tar_vld_d;
    logic [31:0]     tar_q, tar_d;

    adiv5_resp_t     rsp;
    adiv5_cmd_t      cmd;
    logic            push, pop, bad_ack, can_push, done;

    assign rsp      = bus.ADIv5_RDDATA;
    assign pop      = !bus.ADIv5_RDEMPTY && (outst_q != '0);
    assign bad_ack  = pop && (rsp.ack != ACK_OK);
    // A fault popped this cycle already blocks the push of the same cycle.
    assign can_push = !bus.ADIv5_WRFULL && (outst_q != OW'(MAX_OUTST)) && !err_q && !bad_ack;
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        sel_vld_d  = sel_vld_q;
        csw_vld_d  = csw_vld_q;
        csw_size_d = csw_size_q;
        tar_vld_d  = tar_vld_q;
        tar_d      = tar_q;
        push       = 1'b0;
        cmd        = '0;

        case (state_q)
            S_IDLE: if (bus.REQ_VALID && rdy_q) begin
                wr_d    = bus.REQ_WRITE;
                size_d  = (bus.REQ_SIZE == 2'd3) ? 2'd2 : bus.REQ_SIZE;
                addr_d  = bus.REQ_ADDR;
                wdata_d = bus.REQ_WDATA;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = S_SEL;
            end
            S_SEL: begin
                if (err_q || bad_ack) state_d = S_DRAIN;
                else if (sel_vld_q)   state_d = S_CSW;
                else if (can_push) begin
                    push      = 1'b1;
                    cmd       = '{data: {AP_SEL, 24'h0}, a: DP_SELECT, apndp: 1'b0, rnw: 1'b0};
                    sel_vld_d = 1'b1;
                    state_d   = S_CSW;
                end
            end
            S_CSW: begin
                if (err_q || bad_ack) state_d = S_DRAIN;
                else if (csw_vld_q && csw_size_q == size_q) state_d = S_TAR;
                else if (can_push) begin
                    push       = 1'b1;
                    cmd        = '{data: CSW_BASE | CSW_INC | {30'h0, size_q}, a: AP_CSW,
                                   apndp: 1'b1, rnw: 1'b0};
                    csw_vld_d  = 1'b1;
                    csw_size_d = size_q;
                    state_d    = S_TAR;
                end
            end
            S_TAR: begin
                if (err_q || bad_ack) state_d = S_DRAIN;
                else if (tar_vld_q && tar_q == addr_q) state_d = S_DRW;
                else if (can_push) begin
                    push      = 1'b1;
                    cmd       = '{data: addr_q, a: AP_TAR, apndp: 1'b1, rnw: 1'b0};
                    tar_vld_d = 1'b1;
                    tar_d     = addr_q;
                    state_d   = S_DRW;
                end
            end
            S_DRW: begin
                if (err_q || bad_ack) state_d = S_DRAIN;
                else if (can_push) begin
                    push    = 1'b1;
                    cmd     = '{data: wr_q ? wdata_q : 32'h0, a: AP_DRW, apndp: 1'b1, rnw: !wr_q};
`ifdef ADIv5_AUTOINC_EN
                    // The AP advanced TAR; leaving the 1 KiB page makes it unpredictable.
                    tar_d     = tar_q + (32'd1 << size_q);
                    tar_vld_d = tar_vld_q && (tar_d[31:10] == tar_q[31:10]);
`endif
                    state_d = wr_q ? S_DRAIN : S_RDBUF;
                end
            end
            S_RDBUF: begin
                if (err_q || bad_ack) state_d = S_DRAIN;
                else if (can_push) begin
                    push    = 1'b1;
                    cmd     = '{data: 32'h0, a: DP_RDBUFF, apndp: 1'b0, rnw: 1'b1};
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (outst_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // RDBUFF is the last command of a read, so its data is the last OK pop.
        if (pop) begin
            if (bad_ack)    err_d   = 1'b1;
            else if (!wr_q) rdata_d = rsp.data;
        end

        if (bad_ack || bus.INVALIDATE) begin
            sel_vld_d = 1'b0;
            csw_vld_d = 1'b0;
            tar_vld_d = 1'b0;
        end
    end

    assign outst_d = outst_q + OW'(push) - OW'(pop);
    assign rdy_d   = (state_d == S_IDLE);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            outst_q    <= '0;
            sel_vld_q  <= 1'b0;
            csw_vld_q  <= 1'b0;
            csw_size_q <= '0;
            tar_vld_q  <= 1'b0;
            tar_q      <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            outst_q    <= outst_d;
            sel_vld_q  <= sel_vld_d;
            csw_vld_q  <= csw_vld_d;
            csw_size_q <= csw_size_d;
            tar_vld_q  <= tar_vld_d;
            tar_q      <= tar_d;
        end
    end

    assign bus.REQ_READY    = rdy_q;
    assign bus.ADIv5_WREN   = push;
    assign bus.ADIv5_WRDATA = cmd;
    assign bus.ADIv5_RDEN   = pop;
    assign bus.RESP_VALID   = done;
    assign bus.RESP_ERR     = done && err_q;
    assign bus.RESP_RDATA   = (done && !wr_q && !err_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_adiv5_mem_seq.sv
// Bench: emulated MEM-AP target behind the command/response FIFOs, a list-level
// reference model feeding expected commands/completions to a negedge scoreboard.
module tb_adiv5_mem_seq;
    import adiv5_mem_seq_pkg::*;

`ifdef ADIv5_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    adiv5_mem_seq_if bus();

    adiv5_mem_seq #(.AP_SEL(8'h00), .CSW_BASE(32'h2300_0000), .MAX_OUTST(3))
        dut (.CLK(CLK), .RESETn(RESETn), .bus(bus.slave));

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0, resp_cnt = 0, last_pop = 0;
    int lat_max = 2, fault_at = -1, tcmd_cnt = 0;

    typedef struct { logic [31:0] rdata; logic err; } exp_rsp_t;
    typedef struct { logic [34:0] d; int due; } tq_t;
    logic [35:0] exp_cmd[$];
    exp_rsp_t    exp_rsp[$];
    tq_t         rq[$];

    // reference model state
    bit          m_sel, m_csw, m_tarv;
    logic [1:0]  m_csz;
    logic [31:0] m_tar;
    logic [31:0] mdl_mem[logic [29:0]];
    // emulated target state
    logic [31:0] t_csw, t_tar, t_latch;
    logic [31:0] tmem[logic [29:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] m;
        case (sz)
            2'd0:    m = 32'h0000_00FF << {a[1:0], 3'b000};
            2'd1:    m = 32'h0000_FFFF << {a[1], 4'b0000};
            default: m = 32'hFFFF_FFFF;
        endcase
        return (old & ~m) | (wd & m);
    endfunction

    // Expected command list and completion for one request; fault_rel truncates at that command.
    task automatic model_req(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input int fault_rel);
        logic [35:0] cl[$];
        logic [1:0]  sz;
        logic [31:0] nt, old, rd;
        exp_rsp_t    r;
        sz = (size == 2'd3) ? 2'd2 : size;
        if (!m_sel) cl.push_back({32'h0, 2'b10, 1'b0, 1'b0});
        m_sel = 1;
        if (!(m_csw && m_csz == sz))
            cl.push_back({32'h2300_0000 | (AUTOINC ? 32'h10 : 32'h0) | {30'h0, sz}, 2'b00, 1'b1, 1'b0});
        m_csw = 1; m_csz = sz;
        if (!(m_tarv && m_tar == addr)) cl.push_back({addr, 2'b01, 1'b1, 1'b0});
        m_tarv = 1; m_tar = addr;
        cl.push_back({wr ? wdata : 32'h0, 2'b11, 1'b1, !wr});
        if (AUTOINC) begin
            nt = m_tar + (32'd1 << sz);
            if (nt[31:10] != m_tar[31:10]) m_tarv = 0;
            m_tar = nt;
        end
        if (!wr) cl.push_back({32'h0, 2'b11, 1'b0, 1'b1});
        old = mdl_mem.exists(addr[31:2]) ? mdl_mem[addr[31:2]] : dflt({addr[31:2], 2'b00});
        rd  = wr ? 32'h0 : old;
        if (fault_rel >= 0) begin
            while (cl.size() > fault_rel + 1) void'(cl.pop_back());
            m_sel = 0; m_csw = 0; m_tarv = 0;
            r.rdata = 32'h0; r.err = 1'b1;
        end else begin
            if (wr) mdl_mem[addr[31:2]] = merge(old, wdata, addr, sz);
            r.rdata = rd; r.err = 1'b0;
        end
        foreach (cl[i]) exp_cmd.push_back(cl[i]);
        exp_rsp.push_back(r);
    endtask

    task automatic target_exec(input logic [35:0] c);
        logic [31:0] d, rd, w;
        logic [2:0]  ack;
        tq_t         e;
        d = c[35:4]; rd = 32'h0;
        if (!c[1] && c[3:2] == 2'b11 && c[0]) rd = t_latch;
        else if (c[1] && c[3:2] == 2'b00) t_csw = d;
        else if (c[1] && c[3:2] == 2'b01) t_tar = d;
        else if (c[1] && c[3:2] == 2'b11) begin
            w = tmem.exists(t_tar[31:2]) ? tmem[t_tar[31:2]] : dflt({t_tar[31:2], 2'b00});
            if (c[0]) t_latch = w;
            else tmem[t_tar[31:2]] = merge(w, d, t_tar, t_csw[1:0]);
            if (t_csw[5:4] == 2'b01) t_tar = t_tar + (32'd1 << t_csw[2:0]);
        end
        ack = (tcmd_cnt == fault_at) ? ACK_FAULT : ACK_OK;
        tcmd_cnt++;
        e.d = {rd, ack};
        e.due = cyc + int'($urandom_range(0, lat_max));
        rq.push_back(e);
    endtask

    // Target: sample FIFO strobes at negedge, apply just after the following posedge.
    initial begin
        logic s_wren, s_rden;
        logic [35:0] s_cmd;
        bus.ADIv5_RDEMPTY = 1'b1;
        bus.ADIv5_RDDATA  = '0;
        forever begin
            @(negedge CLK);
            s_wren = bus.ADIv5_WREN; s_rden = bus.ADIv5_RDEN; s_cmd = bus.ADIv5_WRDATA;
            @(posedge CLK); #1;
            if (!RESETn) rq.delete();
            else begin
                if (s_rden && rq.size() > 0) void'(rq.pop_front());
                if (s_wren) target_exec(s_cmd);
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                bus.ADIv5_RDEMPTY = 1'b0; bus.ADIv5_RDDATA = rq[0].d;
            end else begin
                bus.ADIv5_RDEMPTY = 1'b1; bus.ADIv5_RDDATA = '0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge CLK) begin
        logic [35:0] e;
        exp_rsp_t    r;
        cyc++;
        if (RESETn) begin
            if (bus.ADIv5_WREN) begin
                n_chk++;
                if (exp_cmd.size() == 0) begin
                    n_fail++; $display("FAIL cmd_unexpected got=%h", bus.ADIv5_WRDATA);
                end else begin
                    e = exp_cmd.pop_front();
                    if (bus.ADIv5_WRDATA !== e) begin
                        n_fail++; $display("FAIL cmd got=%h exp=%h", bus.ADIv5_WRDATA, e);
                    end
                end
            end
            if (bus.ADIv5_WRFULL) begin
                n_chk++;
                if (bus.ADIv5_WREN !== 1'b0) begin
                    n_fail++; $display("FAIL wren_while_full got=%b exp=0", bus.ADIv5_WREN);
                end
            end
            if (bus.ADIv5_RDEN) begin
                last_pop = cyc;
                n_chk++;
                if (bus.ADIv5_RDEMPTY) begin
                    n_fail++; $display("FAIL rden_while_empty got=1 exp=0");
                end
            end
            if (bus.RESP_VALID) begin
                n_chk++;
                if (exp_rsp.size() == 0) begin
                    n_fail++; $display("FAIL resp_unexpected rdata=%h", bus.RESP_RDATA);
                end else begin
                    r = exp_rsp.pop_front();
                    if (bus.RESP_RDATA !== r.rdata || bus.RESP_ERR !== r.err) begin
                        n_fail++;
                        $display("FAIL resp got=%h/%b exp=%h/%b", bus.RESP_RDATA, bus.RESP_ERR, r.rdata, r.err);
                    end
                end
                n_chk++;
                if (cyc - last_pop < 2) begin
                    n_fail++; $display("FAIL resp_latency got=%0d exp>=2", cyc - last_pop);
                end
                resp_cnt++;
            end
        end
    end

    task automatic do_req(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int fault_rel, input int full_after);
        int start, k;
        model_req(wr, size, addr, wdata, fault_rel);
        start = resp_cnt;
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b1; bus.REQ_WRITE = wr; bus.REQ_SIZE = size;
        bus.REQ_ADDR = addr; bus.REQ_WDATA = wdata;
        k = 0;
        do begin @(negedge CLK); k++; end while (!bus.REQ_READY && k < 50);
        n_chk++;
        if (!bus.REQ_READY) begin n_fail++; $display("FAIL req_accept_timeout got=0 exp=1"); end
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b0;
        if (full_after >= 0) begin
            repeat (full_after) @(posedge CLK);
            #1 bus.ADIv5_WRFULL = 1'b1;
            repeat (10) @(posedge CLK);
            #1 bus.ADIv5_WRFULL = 1'b0;
        end
        k = 0;
        while (resp_cnt == start && k < 300) begin @(negedge CLK); k++; end
        n_chk++;
        if (resp_cnt == start) begin
            n_fail++; $display("FAIL resp_timeout addr=%h got=none exp=completion", addr);
            exp_rsp.delete();
        end
        n_chk++;
        if (exp_cmd.size() != 0) begin
            n_fail++; $display("FAIL cmd_missing got=%0d_left exp=0", exp_cmd.size());
            exp_cmd.delete();
        end
    endtask

    task automatic pulse_inval();
        @(posedge CLK); #1 bus.INVALIDATE = 1'b1;
        @(posedge CLK); #1 bus.INVALIDATE = 1'b0;
        m_sel = 0; m_csw = 0; m_tarv = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin n_fail++; $display("FAIL %s got=%h exp=%h", nm, got, exp); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, last_a;
        logic [1:0]  sz;
        bit          wr;
        bus.REQ_VALID = 0; bus.REQ_WRITE = 0; bus.REQ_SIZE = 0; bus.REQ_ADDR = 0;
        bus.REQ_WDATA = 0; bus.INVALIDATE = 0; bus.ADIv5_WRFULL = 0;
        m_sel = 0; m_csw = 0; m_tarv = 0; m_csz = 0; m_tar = 0;
        t_csw = 0; t_tar = 0; t_latch = 0;
        mdl_mem[30'h0800_0000] = 32'hDEAD_BEEF;
        tmem[30'h0800_0000]    = 32'hDEAD_BEEF;

        repeat (3) @(negedge CLK);
        chk("rst_req_ready", {31'h0, bus.REQ_READY}, 32'h0);
        chk("rst_resp_valid", {31'h0, bus.RESP_VALID}, 32'h0);
        chk("rst_resp_rdata", bus.RESP_RDATA, 32'h0);
        chk("rst_resp_err", {31'h0, bus.RESP_ERR}, 32'h0);
        chk("rst_wren", {31'h0, bus.ADIv5_WREN}, 32'h0);
        chk("rst_rden", {31'h0, bus.ADIv5_RDEN}, 32'h0);
        @(posedge CLK); #1 RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_req_ready", {31'h0, bus.REQ_READY}, 32'h1);

        do_req(0, 2'd2, 32'h2000_0000, 32'h0, -1, -1);
        do_req(0, 2'd2, 32'h2000_0000, 32'h0, -1, -1);
        do_req(1, 2'd0, 32'h2000_0001, 32'h0000_5500, -1, -1);
        do_req(0, 2'd2, 32'h2000_0000, 32'h0, -1, -1);

        lat_max = 0;
        fault_at = tcmd_cnt;
        do_req(0, 2'd2, 32'h2000_0100, 32'h0, 0, -1);
        fault_at = -1;
        do_req(0, 2'd2, 32'h2000_0100, 32'h0, -1, -1);
        lat_max = 2;

        pulse_inval();
        do_req(0, 2'd2, 32'h2000_0040, 32'h0, -1, 1);
        do_req(1, 2'd1, 32'h2000_0042, 32'hBEEF_0000, -1, 2);

        do_req(0, 2'd2, 32'h0000_03FC, 32'h0, -1, -1);
        do_req(0, 2'd2, 32'h0000_0400, 32'h0, -1, -1);
        do_req(0, 2'd2, 32'h0000_0000, 32'h0, -1, -1);
        do_req(0, 2'd2, 32'h0000_0004, 32'h0, -1, -1);

        last_a = 32'h2000_0000;
        for (int i = 0; i < 40; i++) begin
            lat_max = int'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                a = last_a + 32'd4; sz = 2'd2;
            end else begin
                a = 32'h2000_0000 + (32'($urandom_range(0, 7)) << 2);
                if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
                else if (sz == 2'd1) a = a + (32'($urandom_range(0, 1)) << 1);
            end
            if ($urandom_range(0, 5) == 0) pulse_inval();
            do_req(wr, sz, a, $urandom, -1, ($urandom_range(0, 4) == 0) ? 1 : -1);
            last_a = a;
        end

        repeat (5) @(negedge CLK);
        chk("exp_rsp_left", exp_rsp.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
